// File: rtl/seg7_pkg.sv
// Shared definitions for the HEX display path: active-low segment codes,
// scheduler state encoding, digit-count limits and the nibble decode function.
package seg7_pkg;

  // Largest number of displays a scheduler instance may drive.
  localparam int MAX_DIGITS = 8;
  // Width of the digit index counter, sized for MAX_DIGITS.
  localparam int IDX_W      = 3;

  // Active-low segment patterns, bit0=a ... bit6=g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scheduler states; encoding is fixed so debug probes can read it directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Map a hex nibble onto its active-low seven-segment pattern.
  function automatic logic [6:0] seg7_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      4'hF:    code = SEG_F;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Value-in / segments-out bundle between the datapath and the display scheduler.
// The master side presents values; the slave side is the scheduler.
interface hex_display_scheduler_if #(
  parameter int N_DIGITS = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*N_DIGITS-1:0] in_value;
  logic                  blank_lz;
  logic                  busy;
  logic                  done;
  logic [7*N_DIGITS-1:0] hex_o;

  modport master (
    output in_valid,
    output in_value,
    output blank_lz,
    input  in_ready,
    input  busy,
    input  done,
    input  hex_o
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  blank_lz,
    output in_ready,
    output busy,
    output done,
    output hex_o
  );

endinterface

// File: rtl/seg7_decode.sv
// Shared nibble-to-seven-segment decoder with one register stage.
// The output reflects the nibble presented on the previous clock edge.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_q;

  // Register the decoded pattern; consumers track the one-cycle latency.
  always_ff @(posedge clk) begin
    seg_q <= seg7_code(nibble_i);
  end

  assign seg_o = seg_q;

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-multiplexes one seven-segment decoder across N_DIGITS HEX displays.
// Nibbles are decoded one per cycle into staging registers; all displays are
// then updated in a single cycle so a partially converted value never shows.
module hex_display_scheduler
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_display_scheduler_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // Scheduler state and captured request.
  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d_q;     // index of the nibble now leaving the decoder
  logic                  wb_q;        // decoder output is a valid write-back this cycle
  logic [4*N_DIGITS-1:0] value_q;
  logic                  blank_lz_q;

  // Registered outputs.
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7*N_DIGITS-1:0] hex_q;

  // Staging registers and their next-state values.
  logic [6:0]            stage_q [N_DIGITS];
  logic [6:0]            stage_d [N_DIGITS];

  // Decoder interface and commit-side combinational values.
  logic [3:0]            nib_s;
  logic [6:0]            dec_s;
  logic [N_DIGITS-1:0]   blank_s;
  logic                  lz_run_s;
  logic [7*N_DIGITS-1:0] hex_d;

  // Select the nibble addressed by the issue index.
  always_comb begin
    nib_s = 4'(value_q >> {idx_q, 2'b00});
  end

  seg7_decode u_decode (
    .clk      (clk),
    .nibble_i (nib_s),
    .seg_o    (dec_s)
  );

  // Route the decoder write-back into the staging slot it belongs to.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      if (wb_q && (idx_d_q == IDX_W'(i))) begin
        stage_d[i] = dec_s;
      end else begin
        stage_d[i] = stage_q[i];
      end
    end
  end

  // Build the leading-zero blank mask from the captured value, scanning down
  // from the most significant nibble; display 0 always stays visible.
  always_comb begin
    lz_run_s = 1'b1;
    blank_s  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run_s   = lz_run_s & (value_q[4*i +: 4] == 4'h0);
      blank_s[i] = blank_lz_q & lz_run_s & (i != 0);
    end
  end

  // Assemble the committed display word from the staging values that will be
  // present after this edge, so the final write-back and commit coincide.
  always_comb begin
    hex_d = {N_DIGITS{SEG_BLANK}};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (blank_s[i]) begin
        hex_d[7*i +: 7] = SEG_BLANK;
      end else begin
        hex_d[7*i +: 7] = stage_d[i];
      end
    end
  end

  // Staging register bank, cleared to blank on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        stage_q[i] <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Scheduler FSM: issue sequencing, write-back tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      idx_d_q    <= '0;
      wb_q       <= 1'b0;
      value_q    <= '0;
      blank_lz_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hex_q      <= {N_DIGITS{SEG_BLANK}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          wb_q   <= 1'b0;
          done_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            value_q    <= bus.in_value;
            blank_lz_q <= bus.blank_lz;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          idx_d_q <= idx_q;
          wb_q    <= 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_FLUSH;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_FLUSH: begin
          // Last write-back lands this edge; hex_d already includes it.
          wb_q    <= 1'b0;
          hex_q   <= hex_d;
          done_q  <= 1'b1;
          state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          wb_q       <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hex_o    = hex_q;

endmodule
